// File: rtl/note_pkg.sv
// Shared definitions for the solfege tone detector and the tone generators.
// All counts are stored at a 25 MHz reference clock and scaled to the real
// clock frequency, so a design running at any CLK_HZ keeps the same pitches.
package note_pkg;

  typedef enum logic [2:0] {
    NOTE_DO   = 3'd0,
    NOTE_RE   = 3'd1,
    NOTE_MI   = 3'd2,
    NOTE_FA   = 3'd3,
    NOTE_SOL  = 3'd4,
    NOTE_LA   = 3'd5,
    NOTE_SI   = 3'd6,
    NOTE_NONE = 3'd7
  } note_e;

  localparam longint unsigned REF_CLK_HZ = 64'd25000000;

  // Nominal half-periods at the reference clock (what the generators emit).
  localparam int unsigned HP_DO  = 47709;
  localparam int unsigned HP_RE  = 42517;
  localparam int unsigned HP_MI  = 37878;
  localparam int unsigned HP_FA  = 35816;
  localparam int unsigned HP_SOL = 31887;
  localparam int unsigned HP_LA  = 28409;
  localparam int unsigned HP_SI  = 25303;

  // Classification window edges at the reference clock. Each note owns the
  // range from its own lower edge up to (not including) the next one; the
  // top of the do window is inclusive and also serves as the silence limit.
  localparam int unsigned BND_SI_LO  = 24038;
  localparam int unsigned BND_LA_LO  = 26856;
  localparam int unsigned BND_SOL_LO = 30148;
  localparam int unsigned BND_FA_LO  = 33851;
  localparam int unsigned BND_MI_LO  = 36847;
  localparam int unsigned BND_RE_LO  = 40197;
  localparam int unsigned BND_DO_LO  = 45113;
  localparam int unsigned BND_DO_HI  = 50094;

  typedef struct packed {
    logic [31:0] siLo;
    logic [31:0] laLo;
    logic [31:0] solLo;
    logic [31:0] faLo;
    logic [31:0] miLo;
    logic [31:0] reLo;
    logic [31:0] doLo;
    logic [31:0] doHi;
  } bounds_t;

  // Rescale a reference-clock count to a clock of clkHz (truncating).
  function automatic logic [31:0] scaleCount(input int unsigned refCount,
                                             input longint unsigned clkHz);
    longint unsigned wide;
    wide = 64'(refCount) * clkHz / REF_CLK_HZ;
    return wide[31:0];
  endfunction

  // Window edges for a given clock frequency.
  function automatic bounds_t makeBounds(input longint unsigned clkHz);
    bounds_t b;
    b.siLo  = scaleCount(BND_SI_LO, clkHz);
    b.laLo  = scaleCount(BND_LA_LO, clkHz);
    b.solLo = scaleCount(BND_SOL_LO, clkHz);
    b.faLo  = scaleCount(BND_FA_LO, clkHz);
    b.miLo  = scaleCount(BND_MI_LO, clkHz);
    b.reLo  = scaleCount(BND_RE_LO, clkHz);
    b.doLo  = scaleCount(BND_DO_LO, clkHz);
    b.doHi  = scaleCount(BND_DO_HI, clkHz);
    return b;
  endfunction

  // Nominal half-period of a note for a given clock frequency (0 for none).
  function automatic logic [31:0] halfPeriod(input note_e n,
                                             input longint unsigned clkHz);
    logic [31:0] hp;
    case (n)
      NOTE_DO:  hp = scaleCount(HP_DO, clkHz);
      NOTE_RE:  hp = scaleCount(HP_RE, clkHz);
      NOTE_MI:  hp = scaleCount(HP_MI, clkHz);
      NOTE_FA:  hp = scaleCount(HP_FA, clkHz);
      NOTE_SOL: hp = scaleCount(HP_SOL, clkHz);
      NOTE_LA:  hp = scaleCount(HP_LA, clkHz);
      NOTE_SI:  hp = scaleCount(HP_SI, clkHz);
      default:  hp = 32'd0;
    endcase
    return hp;
  endfunction

  // Map a measured half-period (in clocks) to a note; out of range is NONE.
  function automatic note_e classify(input logic [16:0] p, input bounds_t b);
    logic [31:0] pw;
    note_e cls;
    pw = {15'd0, p};
    if (pw < b.siLo || pw > b.doHi) cls = NOTE_NONE;
    else if (pw < b.laLo)           cls = NOTE_SI;
    else if (pw < b.solLo)          cls = NOTE_LA;
    else if (pw < b.faLo)           cls = NOTE_SOL;
    else if (pw < b.miLo)           cls = NOTE_FA;
    else if (pw < b.reLo)           cls = NOTE_MI;
    else if (pw < b.doLo)           cls = NOTE_RE;
    else                            cls = NOTE_DO;
    return cls;
  endfunction

endpackage

// File: rtl/note_detect_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a change
// detector: edge_o is high for the one cycle in which the synchronized level
// differs from its value one cycle earlier. The edge output carries a suffix
// because the bare word edge is reserved in SystemVerilog.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy of the synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q      = sync_q;
  assign edge_o = sync_q ^ prev_q;

endmodule

// File: rtl/note_detect.sv
// Solfege note detector. Measures the half-period of a square-wave tone,
// classifies it into do..si, and only changes the reported note after STABLE
// consecutive half-periods agree. A long silence forces the note to NONE.
// Pitch windows are scaled from the 25 MHz reference to CLK_HZ; CLK_HZ must
// stay at or below 25 MHz so the silence limit fits the 16-bit counter.
module note_detect
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25000000,
  parameter int unsigned STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sig,
  output logic [2:0] note,
  output logic       chg
);

  localparam bounds_t BOUNDS = makeBounds(64'(CLK_HZ));
  localparam int unsigned MATCH_W = $clog2(STABLE + 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(STABLE);
  localparam logic [15:0] HP_MAX = 16'hFFFF;

  logic               sigEdge;
  logic               syncLevelUnused;

  logic [15:0]        hpCnt_q, hpCnt_d;
  logic               first_q, first_d;
  note_e              cand_q, cand_d;
  logic [MATCH_W-1:0] match_q, match_d;
  note_e              note_q, note_d;
  logic               chg_q, chg_d;

  logic [16:0]        period;
  note_e              measCls;
  logic               timeout;

  sync_edge uSync (
    .clk    (clk),
    .rst    (rst),
    .d      (sig),
    .q      (syncLevelUnused),
    .edge_o (sigEdge)
  );

  // Measurement, debounce and note update. The first edge after a restart
  // only opens a measurement window. An edge beats the silence limit when
  // both happen together, and the limit re-arms only after a new edge.
  always_comb begin
    hpCnt_d = hpCnt_q;
    first_d = first_q;
    cand_d  = cand_q;
    match_d = match_q;
    note_d  = note_q;
    chg_d   = 1'b0;

    period  = {1'b0, hpCnt_q} + 17'd1;
    measCls = classify(period, BOUNDS);
    timeout = ({16'd0, hpCnt_q} > BOUNDS.doHi) && !first_q;

    if (!en) begin
      hpCnt_d = '0;
      first_d = 1'b1;
      cand_d  = NOTE_NONE;
      match_d = '0;
      note_d  = NOTE_NONE;
    end else if (sigEdge) begin
      hpCnt_d = '0;
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        if (measCls == cand_q) begin
          if (match_q != MATCH_FULL) begin
            match_d = match_q + 1'b1;
          end
        end else begin
          cand_d  = measCls;
          match_d = MATCH_W'(1);
        end
        if (match_d == MATCH_FULL && cand_d != note_q) begin
          note_d = cand_d;
          chg_d  = 1'b1;
        end
      end
    end else begin
      if (hpCnt_q != HP_MAX) begin
        hpCnt_d = hpCnt_q + 16'd1;
      end
      if (timeout) begin
        first_d = 1'b1;
        cand_d  = NOTE_NONE;
        match_d = '0;
        if (note_q != NOTE_NONE) begin
          note_d = NOTE_NONE;
          chg_d  = 1'b1;
        end
      end
    end
  end

  // Detector state registers; reset discards any partial measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpCnt_q <= '0;
      first_q <= 1'b1;
      cand_q  <= NOTE_NONE;
      match_q <= '0;
      note_q  <= NOTE_NONE;
      chg_q   <= 1'b0;
    end else begin
      hpCnt_q <= hpCnt_d;
      first_q <= first_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      note_q  <= note_d;
      chg_q   <= chg_d;
    end
  end

  assign note = note_q;
  assign chg  = chg_q;

endmodule

// File: doc/note_detect.md
NOTE_DETECT -- requirements
Module: note_detect

Interface
REQ-001 SHALL expose parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL expose parameter STABLE, default 4, the number of consecutive matching half-periods required before the note changes.
REQ-003 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: detector enable; 0 holds the detector in its idle state.
REQ-006 SHALL have port sig, input, 1 bit: asynchronous square-wave tone input.
REQ-007 SHALL have port note, output, 3 bits: detected note, 0=do, 1=re, 2=mi, 3=fa, 4=sol, 5=la, 6=si, 7=silence/unknown.
REQ-008 SHALL have port chg, output, 1 bit: one-cycle pulse in the same cycle that note takes a new value.

Function
REQ-009 SHALL pass sig through a 2-FF synchronizer; an edge is any change of the synchronized level between consecutive cycles.
REQ-010 SHALL count clocks since the last edge in a 16-bit counter hp_cnt that saturates at 65535.
REQ-011 On an edge, SHALL take the measured half-period as P = hp_cnt + 1 and clear hp_cnt to 0 in the same cycle.
REQ-012 The first edge after reset, after en rises, or after a timeout SHALL only restart hp_cnt; it SHALL NOT produce a measurement.
REQ-013 SHALL classify P using the bounds 24038 / 26856 / 30148 / 33851 / 36847 / 40197 / 45113 / 50094:
- si: 24038 ≤ P < 26856
- la: < 30148
- sol: < 33851
- fa: < 36847
- mi: < 40197
- re: < 45113
- do: ≤ 50094
- anything else: class 7
REQ-014 SHALL hold a candidate class and a match counter (0..STABLE):
- classification equal to the candidate: increment the counter, saturating at STABLE;
- otherwise: load the candidate with the new class and set the counter to 1.
REQ-015 When the match counter reaches STABLE and the candidate differs from note, SHALL load note with the candidate and pulse chg high for exactly 1 cycle.
REQ-016 Timeout: when hp_cnt exceeds 50094 with no edge, SHALL set the candidate to 7 and the counter to 0, and, if note≠7, set note=7 and pulse chg. The timeout SHALL fire once per silent interval.
REQ-017 Latency: note/chg SHALL update no later than 4 clk after the sig transition that completes the STABLE-th matching half-period.
REQ-018 If an edge and the timeout condition occur in the same cycle, the edge SHALL take priority.
REQ-019 While en=0, SHALL hold hp_cnt=0, candidate=7, match=0, note=7, chg=0, and SHALL NOT pulse chg on the en 1→0 transition.
REQ-020 Repeated matching half-periods of the current note SHALL NOT pulse chg again.

Reset
REQ-021 While rst=1, SHALL asynchronously force note=7, chg=0, hp_cnt=0, candidate=7, match=0, synchronizer flops=0, and the first-edge flag set.
REQ-022 Reset asserted mid-measurement SHALL discard all partial state; after release, detection SHALL restart per REQ-012.

Structure
REQ-023 SHALL place the note codes (NOTE_DO..NOTE_SI, NOTE_NONE=7), the nominal half-periods (47709, 42517, 37878, 35816, 31887, 28409, 25303) and the REQ-013 bounds in a shared package note_pkg, reusable by the tone generators.
REQ-024 SHALL implement the synchronizer and edge detect as sub-module sync_edge (inputs clk, rst, d; outputs q, edge).

Verification
REQ-025 Reset, then 10 half-periods of 28409 clk → exactly one chg pulse, note=5, pulse after the 4th measured half-period.
REQ-026 Do tone (47709) for 8 half-periods, then re (42517) → note 0 then 1; exactly 2 chg pulses; the switch occurs 4 measured half-periods after the change.
REQ-027 Alternating half-periods 31887/28409 → no match counter reaches 4; note stays 7; no chg.
REQ-028 Si tone locked, then sig held constant → chg with note=7 when hp_cnt reaches 50095; no further pulses.
REQ-029 rst asserted mid-way through a la tone, released, tone continues → note=7 during reset; la re-detected after the first edge plus 4 half-periods.
REQ-030 en dropped to 0 while note=2 → note=7 with no chg; en re-raised with mi tone → note=2 after the first edge plus 4 half-periods.
